// File: rtl/multicycle_control_fsm.sv
// Multicycle sequencer for the RV32I core: walks each instruction class through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives the datapath controls.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | request instruction word at PC, latch IR on mem_ready
// DECODE    | capture one-hot class; illegal class -> TRAP
// EXECUTE   | ALU operand selects; branches retire here
// MEMORY    | load/store request at ALU-result address
// WRITEBACK | register write, PC update, retire
// TRAP      | sticky fault, all controls idle until reset
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] CODE,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_load,
    output logic       pc_load,
    output logic       pc_src,
    output logic       alu_sel_A,
    output logic       alu_sel_B,
    output logic       alu_pass_b,
    output logic       rd_we,
    output logic [1:0] wb_sel,
    output logic       instr_done,
    output logic       trap,
    output logic [2:0] state
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_TRAP      = 3'd5;

    localparam int C_J     = 0;
    localparam int C_JALR  = 1;
    localparam int C_LUI   = 2;
    localparam int C_AUIPC = 3;
    localparam int C_B     = 4;
    localparam int C_R     = 5;
    localparam int C_S     = 6;
    localparam int C_IALU  = 7;
    localparam int C_LOAD  = 8;
    localparam int C_CSR   = 9;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [2:0]        state_q, state_d;
    logic [9:0]        code_q, code_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic is_j, is_jalr, is_lui, is_auipc, is_b, is_r, is_s, is_ialu, is_load, is_csr;
    logic goes_wb, code_legal, mem_waiting, timeout_hit;
    logic sel_a, sel_b;

    assign is_j     = code_q[C_J];
    assign is_jalr  = code_q[C_JALR];
    assign is_lui   = code_q[C_LUI];
    assign is_auipc = code_q[C_AUIPC];
    assign is_b     = code_q[C_B];
    assign is_r     = code_q[C_R];
    assign is_s     = code_q[C_S];
    assign is_ialu  = code_q[C_IALU];
    assign is_load  = code_q[C_LOAD];
    assign is_csr   = code_q[C_CSR];

    assign goes_wb = is_j | is_jalr | is_lui | is_auipc | is_r | is_ialu | is_csr;
    assign sel_a   = is_j | is_auipc | is_csr;
    assign sel_b   = ~(is_r | is_b);

    assign code_legal = (CODE != 10'd0) && ((CODE & (CODE - 10'd1)) == 10'd0);

    // Only FETCH and MEMORY hold a memory request open.
    assign mem_waiting = ((state_q == S_FETCH) || (state_q == S_MEMORY)) && !mem_ready;
    assign timeout_hit = (MEM_TIMEOUT > 0) && mem_waiting && (wait_q == WAIT_LAST);

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_load    = 1'b0;
        pc_load    = 1'b0;
        pc_src     = 1'b0;
        alu_sel_A  = 1'b0;
        alu_sel_B  = 1'b0;
        alu_pass_b = 1'b0;
        rd_we      = 1'b0;
        wb_sel     = 2'b00;
        instr_done = 1'b0;
        trap       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                code_d  = CODE;
                state_d = code_legal ? S_EXECUTE : S_TRAP;
            end
            S_EXECUTE: begin
                alu_sel_A  = sel_a;
                alu_sel_B  = sel_b;
                alu_pass_b = is_lui;
                if (is_b) begin
                    pc_load    = 1'b1;
                    pc_src     = branch_taken;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (goes_wb) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_MEMORY;
                end
            end
            S_MEMORY: begin
                mem_req   = 1'b1;
                addr_sel  = 1'b1;
                mem_we    = is_s;
                alu_sel_A = sel_a;
                alu_sel_B = sel_b;
                if (mem_ready) begin
                    if (is_s) begin
                        pc_load    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                rd_we      = 1'b1;
                pc_load    = 1'b1;
                instr_done = 1'b1;
                pc_src     = is_j | is_jalr;
                if (is_load)
                    wb_sel = 2'b01;
                else if (is_j | is_jalr)
                    wb_sel = 2'b10;
                else if (is_csr)
                    wb_sel = 2'b11;
                else
                    wb_sel = 2'b00;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        if (timeout_hit)
            state_d = S_TRAP;

        // While reset is held the sequencer issues nothing to the datapath.
        if (reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            addr_sel   = 1'b0;
            ir_load    = 1'b0;
            pc_load    = 1'b0;
            pc_src     = 1'b0;
            alu_sel_A  = 1'b0;
            alu_sel_B  = 1'b0;
            alu_pass_b = 1'b0;
            rd_we      = 1'b0;
            wb_sel     = 2'b00;
            instr_done = 1'b0;
            trap       = 1'b0;
        end
    end

    always_comb begin
        if ((state_d != state_q) || mem_ready)
            wait_d = '0;
        else if (mem_waiting)
            wait_d = wait_q + 1'b1;
        else
            wait_d = wait_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            code_q  <= 10'd0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            wait_q  <= wait_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: stimulus pushes the expected
// retirement record, a negedge monitor pops and compares on every instr_done.
module tb_multicycle_control_fsm;

    localparam int C_J = 0, C_JALR = 1, C_LUI = 2, C_AUIPC = 3, C_B = 4;
    localparam int C_R = 5, C_S = 6, C_IALU = 7, C_LOAD = 8, C_CSR = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] CODE;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, addr_sel, ir_load, pc_load, pc_src;
    logic       alu_sel_A, alu_sel_B, alu_pass_b, rd_we, instr_done, trap;
    logic [1:0] wb_sel;
    logic [2:0] state;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int cls;
        int lat;
        int wb;
        int rd;
        int pcs;
        int we;
        int a;
        int b;
        int p;
    } exp_t;

    exp_t sb[$];

    multicycle_control_fsm #(.MEM_TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .CODE         (CODE),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .addr_sel     (addr_sel),
        .ir_load      (ir_load),
        .pc_load      (pc_load),
        .pc_src       (pc_src),
        .alu_sel_A    (alu_sel_A),
        .alu_sel_B    (alu_sel_B),
        .alu_pass_b   (alu_pass_b),
        .rd_we        (rd_we),
        .wb_sel       (wb_sel),
        .instr_done   (instr_done),
        .trap         (trap),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected retirement record from the class rules, independent of state encoding.
    function automatic exp_t model(input int cls, input int fw, input int mw, input bit bt);
        exp_t e;
        bit is_mem, writes;
        is_mem = (cls == C_S) || (cls == C_LOAD);
        writes = !((cls == C_B) || (cls == C_S));
        e.cls = cls;
        e.lat = fw + 3 + (is_mem ? mw + 1 : 0) + (writes ? 1 : 0);
        e.rd  = writes ? 1 : 0;
        e.we  = (cls == C_S) ? 1 : 0;
        if (cls == C_LOAD)                      e.wb = 1;
        else if (cls == C_J || cls == C_JALR)   e.wb = 2;
        else if (cls == C_CSR)                  e.wb = 3;
        else                                    e.wb = 0;
        if (!writes) e.wb = 0;
        if (cls == C_B)                         e.pcs = bt ? 1 : 0;
        else                                    e.pcs = (cls == C_J || cls == C_JALR) ? 1 : 0;
        e.a = (cls == C_J || cls == C_AUIPC || cls == C_CSR) ? 1 : 0;
        e.b = (cls == C_R || cls == C_B) ? 0 : 1;
        e.p = (cls == C_LUI) ? 1 : 0;
        return e;
    endfunction

    task automatic monitor();
        int  cnt = 0;
        int  saw_rd = 0, saw_we = 0;
        int  ex_a = 0, ex_b = 0, ex_p = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt = 0; saw_rd = 0; saw_we = 0;
            end else begin
                cnt++;
                if (mem_we && !addr_sel) begin
                    miscompares++;
                    $display("FAIL we_without_alu_addr: mem_we=%0d addr_sel=%0d", mem_we, addr_sel);
                end
                if (state == 3'd2) begin
                    ex_a = alu_sel_A; ex_b = alu_sel_B; ex_p = alu_pass_b;
                end
                if (rd_we)  saw_rd = 1;
                if (mem_we) saw_we = 1;
                if (instr_done) begin
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_retire: got instr_done, expected none");
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("latency cls%0d", e.cls), cnt, e.lat);
                        chk($sformatf("wb_sel cls%0d", e.cls), wb_sel, e.wb);
                        chk($sformatf("rd_we cls%0d", e.cls), saw_rd, e.rd);
                        chk($sformatf("pc_src cls%0d", e.cls), pc_src, e.pcs);
                        chk($sformatf("pc_load cls%0d", e.cls), pc_load, 1);
                        chk($sformatf("mem_we cls%0d", e.cls), saw_we, e.we);
                        chk($sformatf("alu_sel_A cls%0d", e.cls), ex_a, e.a);
                        chk($sformatf("alu_sel_B cls%0d", e.cls), ex_b, e.b);
                        chk($sformatf("alu_pass_b cls%0d", e.cls), ex_p, e.p);
                    end
                    cnt = 0; saw_rd = 0; saw_we = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    // Drives one legal instruction from its first FETCH cycle on a fixed schedule.
    task automatic run_instr(input int cls, input int fw, input int mw, input bit bt);
        sb.push_back(model(cls, fw, mw, bt));
        branch_taken = bt;
        for (int i = 0; i < fw; i++) begin
            CODE = 10'($urandom); mem_ready = 1'b0; step();
        end
        CODE = 10'($urandom); mem_ready = 1'b1; step();
        CODE = 10'(1 << cls); mem_ready = 1'($urandom); step();
        CODE = 10'($urandom); mem_ready = 1'($urandom); step();
        if (cls == C_S || cls == C_LOAD) begin
            for (int i = 0; i < mw; i++) begin
                CODE = 10'($urandom); mem_ready = 1'b0; step();
            end
            mem_ready = 1'b1; step();
        end
        if (!(cls == C_B || cls == C_S)) begin
            CODE = 10'($urandom); mem_ready = 1'($urandom); step();
        end
    endtask

    task automatic trap_test(input logic [9:0] bad);
        do_reset();
        CODE = 10'($urandom); mem_ready = 1'b1; step();
        CODE = bad; mem_ready = 1'($urandom); step();
        chk($sformatf("illegal %0h state", bad), state, 5);
        chk($sformatf("illegal %0h trap", bad), trap, 1);
        for (int i = 0; i < 20; i++) begin
            CODE = 10'($urandom); mem_ready = 1'($urandom); branch_taken = 1'($urandom);
            step();
            chk($sformatf("trap hold %0d", i), state, 5);
        end
        chk("trap sticky", trap, 1);
        chk("trap mem_req", mem_req, 0);
        do_reset();
        chk("trap cleared state", state, 0);
        chk("trap cleared flag", trap, 0);
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
    endfunction

    initial begin
        reset = 1'b1; CODE = 10'd0; branch_taken = 1'b0; mem_ready = 1'b0;
        fork
            monitor();
        join_none
        step();
        step();
        chk("reset state", state, 0);
        chk("reset mem_req", mem_req, 0);
        chk("reset trap", trap, 0);
        reset = 1'b0;
        #1;
        chk("fetch mem_req", mem_req, 1);
        chk("fetch addr_sel", addr_sel, 0);

        run_instr(C_R, 0, 0, 1'b0);
        run_instr(C_B, 0, 0, 1'b1);
        run_instr(C_B, 0, 0, 1'b0);
        run_instr(C_LOAD, 0, 3, 1'b0);
        run_instr(C_S, 0, 0, 1'b0);
        run_instr(C_J, 0, 0, 1'b0);
        run_instr(C_JALR, 0, 0, 1'b0);
        run_instr(C_CSR, 0, 0, 1'b0);
        run_instr(C_LUI, 1, 0, 1'b0);
        run_instr(C_AUIPC, 0, 0, 1'b1);
        run_instr(C_IALU, 2, 0, 1'b0);
        run_instr(C_S, 15, 15, 1'b0);

        for (int n = 0; n < 300; n++)
            run_instr($urandom_range(0, 9), rand_wait(), rand_wait(), 1'($urandom));

        for (int i = 0; i < 20 && sb.size() != 0; i++)
            step();
        chk("scoreboard drained", sb.size(), 0);

        trap_test(10'h000);
        trap_test(10'h011);

        // FETCH timeout after 16 waiting cycles
        do_reset();
        mem_ready = 1'b0;
        repeat (15) step();
        chk("timeout pre state", state, 0);
        step();
        chk("timeout state", state, 5);
        chk("timeout trap", trap, 1);

        // ready on the 16th waiting cycle completes normally
        do_reset();
        mem_ready = 1'b0;
        repeat (15) step();
        mem_ready = 1'b1;
        step();
        chk("late ready state", state, 1);

        // reset in the middle of a load's MEMORY phase
        do_reset();
        CODE = 10'($urandom); mem_ready = 1'b1; step();
        CODE = 10'(1 << C_LOAD); step();
        mem_ready = 1'b0; step();
        chk("mid mem state", state, 3);
        chk("mid mem mem_req", mem_req, 1);
        chk("mid mem addr_sel", addr_sel, 1);
        chk("mid mem mem_we", mem_we, 0);
        step();
        reset = 1'b1;
        step();
        chk("mid reset state", state, 0);
        chk("mid reset mem_req", mem_req, 0);
        reset = 1'b0;
        #1;
        run_instr(C_R, 0, 0, 1'b0);
        for (int i = 0; i < 20 && sb.size() != 0; i++)
            step();
        chk("final drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
